// File: rtl/bypass_track_unit.sv
// ============================================================================
// bypass_track_unit
// ----------------------------------------------------------------------------
// Forwarding unit that sits beside the execute stage. It tracks the
// destination register of every instruction that has left execute in a short
// shift register (entry 1 = EM, entry 2 = MW, ...), so it never needs the
// downstream instruction words. For each execute source operand it selects
// the youngest matching stage as the bypass source. It also detects load-use
// hazards, where a load in entry 1 feeds the execute instruction, and inserts
// a single bubble for each one.
//
// Optional feature: define BYPASS_PERF_CNT_EN to add two saturating 16-bit
// performance counters (forwarded cycles and load-use stall cycles).
//
// Parameters
//   ADDR_W   register-index width; register 0 is hardwired zero
//   DEPTH    tracked stages after execute (1..7)
//   NUM_SRC  source operands per execute instruction
//   SEL_W    bypass-select width per operand (2**SEL_W > DEPTH)
//
// Ports
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   ex_valid        in   execute stage holds a real instruction
//   ex_wr_en        in   execute instruction writes a register
//   ex_is_load      in   execute instruction is a load
//   ex_rd           in   execute destination register
//   ex_rs           in   execute sources, operand i at [i*ADDR_W +: ADDR_W]
//   freeze          in   global pipeline stall, holds all tracked state
//   flush           in   kill the execute instruction
//   bypass_sel      out  per operand: 0 = register file, k = stage k result
//   load_use_stall  out  hold fetch/decode/execute, bubble into EM
//   perf_fwd_cnt    out  (BYPASS_PERF_CNT_EN) cycles with a used forward
//   perf_stall_cnt  out  (BYPASS_PERF_CNT_EN) load-use stall cycles
// ============================================================================
module bypass_track_unit #(
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 2,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ex_valid,
    input  logic                      ex_wr_en,
    input  logic                      ex_is_load,
    input  logic [ADDR_W-1:0]         ex_rd,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_rs,
    input  logic                      freeze,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  bypass_sel,
    output logic                      load_use_stall
`ifdef BYPASS_PERF_CNT_EN
    ,
    output logic [15:0]               perf_fwd_cnt,
    output logic [15:0]               perf_stall_cnt
`endif
);

    // Tracked stages. Only entry 1 can cause a load-use hazard (a load in
    // entry 2 or later already has its data), so the load flag is kept for
    // entry 1 alone.
    logic [DEPTH:1]    r_v;
    logic [ADDR_W-1:0] r_rd [1:DEPTH];
    logic              r_ld1;

    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic                     w_ld_hit;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        w_sel    = '0;
        w_ld_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Scan oldest to youngest so the smallest matching k overwrites
            // the others: youngest writer wins.
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_v[k] && (r_rd[k] == ex_rs[i*ADDR_W +: ADDR_W]) &&
                    (ex_rs[i*ADDR_W +: ADDR_W] != '0)) begin
                    w_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
            if (r_ld1 && (w_sel[i*SEL_W +: SEL_W] == SEL_W'(1))) begin
                w_ld_hit = 1'b1;
            end
        end
        // An empty execute slot never forwards.
        if (!ex_valid) begin
            w_sel = '0;
        end
    end

    assign bypass_sel     = w_sel;
    assign load_use_stall = ex_valid & ~flush & w_ld_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: only the valid bits matter functionally; the small rd
            // fields are cleared as well so the state is fully deterministic.
            r_v   <= '0;
            r_ld1 <= 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (!freeze) begin
            for (int k = 2; k <= DEPTH; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            // A stalled instruction stays in execute; a bubble enters EM.
            r_v[1]  <= ex_valid & ex_wr_en & (ex_rd != '0) & ~flush & ~load_use_stall;
            r_rd[1] <= ex_rd;
            r_ld1   <= ex_is_load;
        end
    end

`ifdef BYPASS_PERF_CNT_EN
    logic [15:0] r_fwd_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_fwd_used;

    // bypass_sel is already zero when ex_valid is low.
    assign w_fwd_used = ex_valid & ~load_use_stall & (|w_sel);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (!freeze) begin
            if (w_fwd_used && (r_fwd_cnt != 16'hFFFF)) begin
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
            end
            if (load_use_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign perf_fwd_cnt   = r_fwd_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bypass_track_unit.sv
// Testbench for bypass_track_unit. Three instances: A (default DEPTH=2,
// NUM_SRC=2), B (DEPTH=3, NUM_SRC=3) and C (DEPTH=1). Expected outputs are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// outputs are sampled on the falling edge.
module tb_bypass_track_unit;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // Instance A
    logic       a_ex_valid, a_ex_wr_en, a_ex_is_load, a_freeze, a_flush;
    logic [4:0] a_ex_rd;
    logic [9:0] a_ex_rs;
    logic [5:0] a_sel;
    logic       a_stall;
    // Instance B
    logic        b_ex_valid, b_ex_wr_en, b_ex_is_load, b_freeze, b_flush;
    logic [4:0]  b_ex_rd;
    logic [14:0] b_ex_rs;
    logic [8:0]  b_sel;
    logic        b_stall;
    // Instance C
    logic       c_ex_valid, c_ex_wr_en, c_ex_is_load, c_freeze, c_flush;
    logic [4:0] c_ex_rd;
    logic [9:0] c_ex_rs;
    logic [5:0] c_sel;
    logic       c_stall;
`ifdef BYPASS_PERF_CNT_EN
    logic [15:0] a_pf, a_ps, b_pf, b_ps, c_pf, c_ps;
`endif

    bypass_track_unit u_a (
        .clock(clock), .reset_n(reset_n), .ex_valid(a_ex_valid), .ex_wr_en(a_ex_wr_en),
        .ex_is_load(a_ex_is_load), .ex_rd(a_ex_rd), .ex_rs(a_ex_rs), .freeze(a_freeze),
        .flush(a_flush), .bypass_sel(a_sel), .load_use_stall(a_stall)
`ifdef BYPASS_PERF_CNT_EN
        , .perf_fwd_cnt(a_pf), .perf_stall_cnt(a_ps)
`endif
    );

    bypass_track_unit #(.DEPTH(3), .NUM_SRC(3)) u_b (
        .clock(clock), .reset_n(reset_n), .ex_valid(b_ex_valid), .ex_wr_en(b_ex_wr_en),
        .ex_is_load(b_ex_is_load), .ex_rd(b_ex_rd), .ex_rs(b_ex_rs), .freeze(b_freeze),
        .flush(b_flush), .bypass_sel(b_sel), .load_use_stall(b_stall)
`ifdef BYPASS_PERF_CNT_EN
        , .perf_fwd_cnt(b_pf), .perf_stall_cnt(b_ps)
`endif
    );

    bypass_track_unit #(.DEPTH(1)) u_c (
        .clock(clock), .reset_n(reset_n), .ex_valid(c_ex_valid), .ex_wr_en(c_ex_wr_en),
        .ex_is_load(c_ex_is_load), .ex_rd(c_ex_rd), .ex_rs(c_ex_rs), .freeze(c_freeze),
        .flush(c_flush), .bypass_sel(c_sel), .load_use_stall(c_stall)
`ifdef BYPASS_PERF_CNT_EN
        , .perf_fwd_cnt(c_pf), .perf_stall_cnt(c_ps)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         which;
        logic [8:0] sel;
        logic       stall;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic push_exp(input int which, input logic [8:0] sel, input logic stall,
                            input string tag);
        exp_t e;
        e.which = which; e.sel = sel; e.stall = stall; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [8:0] act_sel;
        logic       act_stall;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        case (e.which)
            0:       begin act_sel = {3'b0, a_sel}; act_stall = a_stall; end
            1:       begin act_sel = b_sel;         act_stall = b_stall; end
            default: begin act_sel = {3'b0, c_sel}; act_stall = c_stall; end
        endcase
        check({e.tag, "_sel"}, 32'(act_sel), 32'(e.sel));
        check({e.tag, "_stall"}, 32'(act_stall), 32'(e.stall));
    endtask

    task automatic idle_all();
        {a_ex_valid, a_ex_wr_en, a_ex_is_load, a_freeze, a_flush} = '0;
        {b_ex_valid, b_ex_wr_en, b_ex_is_load, b_freeze, b_flush} = '0;
        {c_ex_valid, c_ex_wr_en, c_ex_is_load, c_freeze, c_flush} = '0;
        a_ex_rd = '0; a_ex_rs = '0;
        b_ex_rd = '0; b_ex_rs = '0;
        c_ex_rd = '0; c_ex_rs = '0;
    endtask

    // Drive one instance for one cycle, check its outputs, advance past the edge.
    task automatic step(input int which, input logic v, input logic wr, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic fr, input logic fl,
                        input logic [8:0] exp_sel, input logic exp_stall, input string tag);
        idle_all();
        case (which)
            0: begin
                a_ex_valid = v; a_ex_wr_en = wr; a_ex_is_load = ld; a_ex_rd = rd;
                a_ex_rs = {rs1, rs0}; a_freeze = fr; a_flush = fl;
            end
            1: begin
                b_ex_valid = v; b_ex_wr_en = wr; b_ex_is_load = ld; b_ex_rd = rd;
                b_ex_rs = {rs2, rs1, rs0}; b_freeze = fr; b_flush = fl;
            end
            default: begin
                c_ex_valid = v; c_ex_wr_en = wr; c_ex_is_load = ld; c_ex_rd = rd;
                c_ex_rs = {rs1, rs0}; c_freeze = fr; c_flush = fl;
            end
        endcase
        push_exp(which, exp_sel, exp_stall, tag);
        @(negedge clock);
        compare();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with live-looking inputs on every instance.
        idle_all();
        a_ex_valid = 1; a_ex_wr_en = 1; a_ex_is_load = 1; a_ex_rd = 5; a_ex_rs = {5'd5, 5'd5};
        b_ex_valid = 1; b_ex_wr_en = 1; b_ex_rd = 2; b_ex_rs = {5'd2, 5'd2, 5'd2};
        c_ex_valid = 1; c_ex_wr_en = 1; c_ex_is_load = 1; c_ex_rd = 9; c_ex_rs = {5'd9, 5'd9};
        #2;
        push_exp(0, 9'd0, 1'b0, "rst_a");  compare();
        push_exp(1, 9'd0, 1'b0, "rst_b");  compare();
        push_exp(2, 9'd0, 1'b0, "rst_c");  compare();
        repeat (2) @(posedge clock);
        #1;
        push_exp(0, 9'd0, 1'b0, "rst_hold_a"); compare();
        idle_all();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // EM / MW forwarding
        step(0, 1, 1, 0, 5,  0,  0, 0, 0, 0, 9'd0,  0, "em_issue");
        step(0, 1, 0, 0, 0,  5,  3, 0, 0, 0, 9'd1,  0, "em_fwd");
        step(0, 1, 0, 0, 0,  3,  5, 0, 0, 0, 9'd16, 0, "mw_fwd");
        // Youngest writer wins; register 0 never forwards
        step(0, 1, 1, 0, 7,  0,  0, 0, 0, 0, 9'd0,  0, "prio_issue");
        step(0, 1, 1, 0, 7,  7,  7, 0, 0, 0, 9'd9,  0, "prio_first");
        step(0, 1, 0, 0, 0,  7,  7, 0, 0, 0, 9'd9,  0, "prio_youngest");
        step(0, 1, 1, 0, 0,  0,  0, 0, 0, 0, 9'd0,  0, "rd0_issue");
        step(0, 1, 0, 0, 0,  0,  0, 0, 0, 0, 9'd0,  0, "rs0_zero");
        // Load-use: one bubble, then MW forward
        step(0, 1, 1, 1, 9,  0,  0, 0, 0, 0, 9'd0,  0, "ld_issue");
        step(0, 1, 1, 0, 10, 9,  0, 0, 0, 0, 9'd1,  1, "ld_stall");
        step(0, 1, 1, 0, 10, 9,  0, 0, 0, 0, 9'd2,  0, "ld_after");
        step(0, 0, 1, 0, 10, 10, 0, 0, 0, 0, 9'd0,  0, "ex_invalid");
        step(0, 1, 1, 0, 4,  10, 0, 0, 0, 0, 9'd2,  0, "mw_after_bubble");
        // Freeze holds entry 1 for three cycles
        step(0, 1, 1, 0, 11, 4,  0, 0, 1, 0, 9'd1,  0, "freeze1");
        step(0, 1, 1, 0, 11, 4,  0, 0, 1, 0, 9'd1,  0, "freeze2");
        step(0, 1, 1, 0, 11, 4,  0, 0, 1, 0, 9'd1,  0, "freeze3");
        // Flushed writer never becomes a source
        step(0, 1, 1, 0, 6,  4,  0, 0, 0, 1, 9'd1,  0, "flush_issue");
        step(0, 1, 0, 0, 0,  6,  4, 0, 0, 0, 9'd16, 0, "flushed_rd");
        // Freeze and flush together: entries hold
        step(0, 1, 1, 0, 12, 0,  0, 0, 0, 0, 9'd0,  0, "ff_issue");
        step(0, 1, 1, 0, 13, 12, 0, 0, 1, 1, 9'd1,  0, "frz_flush");
        step(0, 1, 0, 0, 0,  12, 13, 0, 0, 0, 9'd1, 0, "frz_flush_hold");
        // Flush masks the load-use stall
        step(0, 1, 1, 1, 14, 0,  0, 0, 0, 0, 9'd0,  0, "ld2_issue");
        step(0, 1, 1, 0, 15, 14, 0, 0, 0, 1, 9'd1,  0, "flush_no_stall");
        step(0, 1, 0, 0, 0,  0,  14, 0, 0, 0, 9'd16, 0, "flush_ld_mw");
        // Two operands from two different stages
        step(0, 1, 1, 0, 8,  0,  0, 0, 0, 0, 9'd0,  0, "two_issue1");
        step(0, 1, 1, 0, 16, 8,  0, 0, 0, 0, 9'd1,  0, "two_issue2");
        step(0, 1, 0, 0, 0,  16, 8, 0, 0, 0, 9'd17, 0, "two_stages");
        step(0, 1, 1, 0, 8,  16, 0, 0, 0, 0, 9'd2,  0, "pre_reset");
`ifdef BYPASS_PERF_CNT_EN
        check("a_perf_fwd", 32'(a_pf), 32'd14);
        check("a_perf_stall", 32'(a_ps), 32'd1);
`endif

        // Asynchronous reset mid-cycle clears entry 1 immediately
        idle_all();
        a_ex_valid = 1; a_ex_rs = {5'd0, 5'd8};
        push_exp(0, 9'd1, 1'b0, "mid_before");
        #2;
        compare();
        reset_n = 1'b0;
        #1;
        push_exp(0, 9'd0, 1'b0, "mid_reset");
        compare();
`ifdef BYPASS_PERF_CNT_EN
        check("mid_reset_perf", 32'(a_pf), 32'd0);
`endif
        idle_all();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // DEPTH=3, NUM_SRC=3: writer walks to stage 3 then leaves
        step(1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 9'd0,   0, "d3_issue");
        step(1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 9'd65,  0, "d3_stage1");
        step(1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 9'd130, 0, "d3_stage2");
        step(1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 9'd195, 0, "d3_stage3");
        step(1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 9'd0,   0, "d3_gone");
`ifdef BYPASS_PERF_CNT_EN
        check("b_perf_fwd", 32'(b_pf), 32'd3);
        check("b_perf_stall", 32'(b_ps), 32'd0);
`endif

        // DEPTH=1: load-use stall clears, operand then reads the register file
        step(2, 1, 1, 1, 9, 0, 0, 0, 0, 0, 9'd0, 0, "d1_ld_issue");
        step(2, 1, 1, 0, 3, 9, 0, 0, 0, 0, 9'd1, 1, "d1_stall");
        step(2, 1, 1, 0, 3, 9, 0, 0, 0, 0, 9'd0, 0, "d1_regfile");
        step(2, 1, 0, 0, 0, 0, 3, 0, 0, 0, 9'd8, 0, "d1_em_fwd");
`ifdef BYPASS_PERF_CNT_EN
        check("c_perf_fwd", 32'(c_pf), 32'd1);
        check("c_perf_stall", 32'(c_ps), 32'd1);
        // Forward every cycle long enough to pass the counter limit
        idle_all();
        c_ex_valid = 1; c_ex_wr_en = 1; c_ex_rd = 1; c_ex_rs = {5'd0, 5'd1};
        repeat (65540) @(posedge clock);
        #1;
        check("c_perf_sat", 32'(c_pf), 32'hFFFF);
        idle_all();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
